// File: rtl/lsu_bus_ctrl.sv
// lsu_bus_ctrl
// Load/store unit sitting behind the single-cycle datapath. It turns the
// datapath's load/store request into one transaction on a
// request/grant/rvalid data-memory bus. It also hands back an aligned,
// sign- or zero-extended load word, and freezes the datapath with stall
// while the transaction is in flight.
//
// Ports
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   mem_read/write  current instruction is a load / store
//   funct3          access size and sign (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   addr, wdata     byte address (ALU result) and store data (rs2)
//   read_data       extended load result, held until the next load
//   stall           hold PC and suppress reg_write this cycle
//   fault           misaligned or illegal access; no bus activity
//   bus_*           data-memory bus: req/we/addr/be/wdata out,
//                   gnt/rvalid/rdata in
module lsu_bus_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       read_data,
  output logic              stall,
  output logic              fault,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic              bus_gnt,
  input  logic              bus_rvalid,
  input  logic [31:0]       bus_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state, state_nxt;
  logic        access, illegal;
  logic        is_half, is_word;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;
  logic [31:0] load_ext;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [2:0]  f3_q;
  logic [1:0]  lo_q;

  assign access  = mem_read | mem_write;
  assign is_half = (funct3[1:0] == 2'b01);
  assign is_word = (funct3[1:0] == 2'b10);

  assign illegal = (mem_read & mem_write)
                 | (funct3 == 3'b011)
                 | (funct3[2:1] == 2'b11)
                 | (mem_write & funct3[2])
                 | (is_half & addr[0])
                 | (is_word & (addr[1:0] != 2'b00));

  // Byte enables and lane-replicated store data. Loads use the same enables.
  always_comb begin
    be_calc    = 4'b1111;
    wdata_calc = wdata;
    case (funct3[1:0])
      2'b00: begin
        be_calc    = 4'b0001 << addr[1:0];
        wdata_calc = {4{wdata[7:0]}};
      end
      2'b01: begin
        be_calc    = 4'b0011 << {addr[1], 1'b0};
        wdata_calc = {2{wdata[15:0]}};
      end
      default: begin
        be_calc    = 4'b1111;
        wdata_calc = wdata;
      end
    endcase
  end

  // Load extraction uses the size and low address bits latched at issue,
  // because the datapath inputs may have moved on by the time rvalid arrives.
  always_comb begin
    byte_sel = bus_rdata[7:0];
    case (lo_q)
      2'b00:   byte_sel = bus_rdata[7:0];
      2'b01:   byte_sel = bus_rdata[15:8];
      2'b10:   byte_sel = bus_rdata[23:16];
      default: byte_sel = bus_rdata[31:24];
    endcase
    half_sel = lo_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (f3_q)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_ext = {24'b0, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_ext = {16'b0, half_sel};
      default: load_ext = bus_rdata;
    endcase
  end

  // Next-state and combinational outputs.
  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    fault     = 1'b0;
    bus_req   = 1'b0;
    case (state)
      IDLE: begin
        if (access && illegal) begin
          fault = 1'b1;
        end else if (access) begin
          stall     = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        bus_req = 1'b1;
        stall   = 1'b1;
        if (bus_gnt) state_nxt = bus_we ? DONE : WAIT;
      end
      WAIT: begin
        stall = 1'b1;
        if (bus_rvalid) state_nxt = DONE;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register plus the latched bus fields. The bus fields are cleared
  // on the way into DONE, so they read as zero in DONE and IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      read_data <= 32'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= 4'b0;
      bus_wdata <= 32'b0;
      f3_q      <= 3'b0;
      lo_q      <= 2'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (access && !illegal) begin
            bus_we    <= mem_write;
            bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
            bus_be    <= be_calc;
            bus_wdata <= wdata_calc;
            f3_q      <= funct3;
            lo_q      <= addr[1:0];
          end
        end
        REQ: begin
          if (bus_gnt && bus_we) begin
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= 4'b0;
            bus_wdata <= 32'b0;
          end
        end
        WAIT: begin
          if (bus_rvalid) begin
            read_data <= load_ext;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= 4'b0;
            bus_wdata <= 32'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// tb_lsu_bus_ctrl
// Drives load/store transactions into lsu_bus_ctrl and plays the memory side
// of the bus. Expected bus fields and load results are queued when a request
// is driven and popped when the DUT is granted.
module tb_lsu_bus_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic [31:0] read_data;
  logic        stall, fault;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt, bus_rvalid;
  logic [31:0] bus_rdata;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rd;
  } exp_t;

  exp_t exp_q[$];

  lsu_bus_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
    .addr(addr), .wdata(wdata),
    .read_data(read_data), .stall(stall), .fault(fault),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] act,
                             input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, act, exp);
    end
  endtask

  // One legal transaction. Entered and left at posedge+1 with the DUT in
  // IDLE. gnt_dly = REQ cycles without grant; rv_dly = WAIT cycles before
  // rvalid.
  task automatic applyStimulus(input logic rd, input logic wr,
                               input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] wd, input logic [31:0] rdata,
                               input int gnt_dly, input int rv_dly,
                               input logic [31:0] e_addr, input logic [3:0] e_be,
                               input logic [31:0] e_wdata,
                               input logic [31:0] e_rd);
    exp_t e, cur;
    e.we = wr; e.addr = e_addr; e.be = e_be; e.wdata = e_wdata; e.rd = e_rd;
    mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
    exp_q.push_back(e);
    @(negedge clk);
    checkOutput("idle_stall", {31'b0, stall}, 32'd1);
    checkOutput("idle_fault", {31'b0, fault}, 32'd0);
    checkOutput("idle_req", {31'b0, bus_req}, 32'd0);
    for (int k = 0; k <= gnt_dly; k++) begin
      @(posedge clk); #1;
      bus_gnt = (k == gnt_dly);
      @(negedge clk);
      checkOutput("req_req", {31'b0, bus_req}, 32'd1);
      checkOutput("req_stall", {31'b0, stall}, 32'd1);
      checkOutput("req_addr", bus_addr, exp_q[0].addr);
      checkOutput("req_be", {28'b0, bus_be}, {28'b0, exp_q[0].be});
      checkOutput("req_we", {31'b0, bus_we}, {31'b0, exp_q[0].we});
      if (wr) checkOutput("req_wdata", bus_wdata, exp_q[0].wdata);
    end
    cur = exp_q.pop_front();
    @(posedge clk); #1;
    bus_gnt = 1'b0;
    if (rd) begin
      for (int k = 0; k <= rv_dly; k++) begin
        bus_rvalid = (k == rv_dly);
        bus_rdata  = (k == rv_dly) ? rdata : 32'hA5A5_A5A5;
        @(negedge clk);
        checkOutput("wait_req", {31'b0, bus_req}, 32'd0);
        checkOutput("wait_stall", {31'b0, stall}, 32'd1);
        @(posedge clk); #1;
      end
      bus_rvalid = 1'b0;
    end
    mem_read = 1'b0; mem_write = 1'b0;
    @(negedge clk);
    checkOutput("done_stall", {31'b0, stall}, 32'd0);
    checkOutput("done_req", {31'b0, bus_req}, 32'd0);
    checkOutput("done_be", {28'b0, bus_be}, 32'd0);
    checkOutput("done_we", {31'b0, bus_we}, 32'd0);
    checkOutput("read_data", read_data, cur.rd);
    @(posedge clk); #1;
  endtask

  task automatic applyFault(input string tag, input logic rd, input logic wr,
                            input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] e_rd);
    mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = 32'h1111_2222;
    @(negedge clk);
    checkOutput({tag, "_fault"}, {31'b0, fault}, 32'd1);
    checkOutput({tag, "_stall"}, {31'b0, stall}, 32'd0);
    checkOutput({tag, "_req"}, {31'b0, bus_req}, 32'd0);
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
    @(negedge clk);
    checkOutput({tag, "_req_after"}, {31'b0, bus_req}, 32'd0);
    checkOutput({tag, "_rd"}, read_data, e_rd);
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1;
    mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b0; addr = 32'b0; wdata = 32'b0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'b0;
    @(negedge clk);
    checkOutput("rst_read_data", read_data, 32'd0);
    checkOutput("rst_stall", {31'b0, stall}, 32'd0);
    checkOutput("rst_fault", {31'b0, fault}, 32'd0);
    checkOutput("rst_req", {31'b0, bus_req}, 32'd0);
    checkOutput("rst_we", {31'b0, bus_we}, 32'd0);
    checkOutput("rst_addr", bus_addr, 32'd0);
    checkOutput("rst_be", {28'b0, bus_be}, 32'd0);
    checkOutput("rst_wdata", bus_wdata, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // rd wr f3 addr wdata rdata gnt rv | exp addr be wdata read_data
    applyStimulus(0, 1, 3'b010, 32'h104, 32'hDEADBEEF, 32'h0, 0, 0,
                  32'h104, 4'b1111, 32'hDEADBEEF, 32'h0);
    applyStimulus(1, 0, 3'b000, 32'h203, 32'h0, 32'h80FF7F01, 2, 1,
                  32'h200, 4'b1000, 32'h0, 32'hFFFFFF80);
    applyStimulus(1, 0, 3'b101, 32'h202, 32'h0, 32'h80FF7F01, 0, 0,
                  32'h200, 4'b1100, 32'h0, 32'h000080FF);
    applyStimulus(1, 0, 3'b001, 32'h202, 32'h0, 32'h80FF7F01, 1, 0,
                  32'h200, 4'b1100, 32'h0, 32'hFFFF80FF);
    applyStimulus(0, 1, 3'b000, 32'h101, 32'h000000AB, 32'h0, 0, 0,
                  32'h100, 4'b0010, 32'hABABABAB, 32'hFFFF80FF);
    applyStimulus(0, 1, 3'b001, 32'h102, 32'h00001234, 32'h0, 1, 0,
                  32'h100, 4'b1100, 32'h12341234, 32'hFFFF80FF);
    applyStimulus(1, 0, 3'b100, 32'h201, 32'h0, 32'h80FF7F01, 0, 2,
                  32'h200, 4'b0010, 32'h0, 32'h0000007F);
    applyStimulus(1, 0, 3'b010, 32'h200, 32'h0, 32'h80FF7F01, 0, 0,
                  32'h200, 4'b1111, 32'h0, 32'h80FF7F01);

    applyFault("lw_mis", 1, 0, 3'b010, 32'h102, 32'h80FF7F01);
    applyFault("rd_wr", 1, 1, 3'b010, 32'h100, 32'h80FF7F01);
    applyFault("f3_011", 1, 0, 3'b011, 32'h100, 32'h80FF7F01);
    applyFault("sbu", 0, 1, 3'b100, 32'h100, 32'h80FF7F01);
    applyFault("lh_mis", 1, 0, 3'b001, 32'h101, 32'h80FF7F01);

    // Reset while waiting for read data; a late rvalid must be ignored.
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h300;
    @(posedge clk); #1;
    bus_gnt = 1'b1;
    @(posedge clk); #1;
    bus_gnt = 1'b0; mem_read = 1'b0;
    @(negedge clk);
    checkOutput("pre_rst_stall", {31'b0, stall}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_read_data", read_data, 32'd0);
    checkOutput("mid_rst_stall", {31'b0, stall}, 32'd0);
    checkOutput("mid_rst_addr", bus_addr, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    bus_rvalid = 1'b1; bus_rdata = 32'h12345678;
    @(negedge clk);
    checkOutput("late_rv_stall", {31'b0, stall}, 32'd0);
    checkOutput("late_rv_req", {31'b0, bus_req}, 32'd0);
    @(posedge clk); #1;
    bus_rvalid = 1'b0;
    @(negedge clk);
    checkOutput("late_rv_read_data", read_data, 32'd0);
    checkOutput("late_rv_stall2", {31'b0, stall}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
